// File: rtl/player_dir_queue.sv
// player_dir_queue: per-player turn-request queues committed to direction on move ticks
module player_dir_queue #(
  parameter int NUM_PLAYERS = 2,
  parameter int QDEPTH = 2,
  parameter logic [2*NUM_PLAYERS-1:0] INIT_DIRS = 4'b11_00
) (
  input  logic                     CLOCK_50,
  input  logic                     resetn,
  input  logic                     clear,
  input  logic                     freeze,
  input  logic                     move_tick,
  input  logic [NUM_PLAYERS-1:0]   dir_valid,
  input  logic [2*NUM_PLAYERS-1:0] dir_req,
  output logic [2*NUM_PLAYERS-1:0] dir_out,
  output logic [NUM_PLAYERS-1:0]   dir_changed,
  output logic [NUM_PLAYERS-1:0]   req_dropped,
  output logic [NUM_PLAYERS-1:0]   q_full
);
  localparam int PW = QDEPTH > 1 ? $clog2(QDEPTH) : 1;
  localparam int CW = $clog2(QDEPTH + 1);
  localparam logic [PW-1:0] PMAX = PW'(QDEPTH - 1);
  localparam logic [CW-1:0] CMAX = CW'(QDEPTH);
  logic act;
  assign act = !freeze && !clear;
  for (genvar i = 0; i < NUM_PLAYERS; i++) begin : g_p
    logic [1:0] mem [QDEPTH];
    logic [1:0] dir, req, tail;
    logic [PW-1:0] rp, wp, lp, rp_n, wp_n;
    logic [CW-1:0] cnt, cnt_n;
    logic pop, push, drop, chg, drp, full;
    always_comb begin
      req = dir_req[2*i +: 2];
      lp = wp == '0 ? PMAX : wp - 1'b1;
      tail = cnt != '0 ? mem[lp] : dir;
      pop = act && move_tick && cnt != '0;
      push = act && dir_valid[i] && req != tail && req != ~tail && (cnt != CMAX || pop);
      drop = act && dir_valid[i] && !push;
      rp_n = rp == PMAX ? '0 : rp + 1'b1;
      wp_n = wp == PMAX ? '0 : wp + 1'b1;
      cnt_n = cnt + CW'(push) - CW'(pop);
    end
    always_ff @(posedge CLOCK_50)
      if (push) mem[wp] <= req;
    always_ff @(posedge CLOCK_50 or negedge resetn)
      if (!resetn || clear) begin
        dir <= INIT_DIRS[2*i +: 2];
        rp <= '0;
        wp <= '0;
        cnt <= '0;
        chg <= 1'b0;
        drp <= 1'b0;
        full <= 1'b0;
      end else begin
        if (pop) dir <= mem[rp];
        if (pop) rp <= rp_n;
        if (push) wp <= wp_n;
        cnt <= cnt_n;
        chg <= pop;
        drp <= drop;
        full <= cnt_n == CMAX;
      end
    assign dir_out[2*i +: 2] = dir;
    assign dir_changed[i] = chg;
    assign req_dropped[i] = drp;
    assign q_full[i] = full;
  end
endmodule

// File: tb/tb_player_dir_queue.sv
// tb_player_dir_queue: random and directed checks of player_dir_queue against a queue-based model
module tb_player_dir_queue;
  localparam int NP = 2;
  localparam int QD = 2;
  localparam logic [3:0] INIT = 4'b11_00;
  logic clk = 0;
  logic resetn = 0;
  logic clear = 0, freeze = 0, move_tick = 0;
  logic [1:0] dir_valid = 0;
  logic [3:0] dir_req = 0;
  logic [3:0] dir_out;
  logic [1:0] dir_changed, req_dropped, q_full;
  int errors = 0, checks = 0;
  logic [1:0] m_dir [NP];
  logic [1:0] mq [NP][$];
  logic [1:0] m_chg, m_drp, m_full;
  player_dir_queue #(.NUM_PLAYERS(NP), .QDEPTH(QD), .INIT_DIRS(INIT)) dut (
    .CLOCK_50(clk), .resetn(resetn), .clear(clear), .freeze(freeze), .move_tick(move_tick),
    .dir_valid(dir_valid), .dir_req(dir_req), .dir_out(dir_out), .dir_changed(dir_changed),
    .req_dropped(req_dropped), .q_full(q_full)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic model_reset();
    for (int p = 0; p < NP; p++) begin
      m_dir[p] = INIT[2*p +: 2];
      mq[p].delete();
    end
    m_chg = 0;
    m_drp = 0;
    m_full = 0;
  endtask
  task automatic model_step();
    logic [1:0] tl, rq;
    logic pop, ok;
    if (clear) begin
      model_reset();
      return;
    end
    m_chg = 0;
    m_drp = 0;
    if (!freeze)
      for (int p = 0; p < NP; p++) begin
        rq = dir_req[2*p +: 2];
        tl = mq[p].size() > 0 ? mq[p][$] : m_dir[p];
        pop = move_tick && mq[p].size() > 0;
        ok = dir_valid[p] && rq != tl && rq != ~tl && (mq[p].size() < QD || pop);
        if (pop) m_dir[p] = mq[p].pop_front();
        if (ok) mq[p].push_back(rq);
        m_chg[p] = pop;
        m_drp[p] = dir_valid[p] && !ok;
      end
    for (int p = 0; p < NP; p++) m_full[p] = mq[p].size() == QD;
  endtask
  task automatic cyc(input logic [1:0] v, input logic [3:0] r, input logic t, input logic fr, input logic cl);
    dir_valid = v;
    dir_req = r;
    move_tick = t;
    freeze = fr;
    clear = cl;
    @(posedge clk);
    model_step();
    #1;
    dir_valid = 0;
    move_tick = 0;
    freeze = 0;
    clear = 0;
  endtask
  always @(negedge clk)
    if (resetn) begin
      chk("dir_out", dir_out, {m_dir[1], m_dir[0]});
      chk("dir_changed", dir_changed, m_chg);
      chk("req_dropped", req_dropped, m_drp);
      chk("q_full", q_full, m_full);
    end
  initial begin
    model_reset();
    #12 resetn = 1;
    @(posedge clk);
    #1;
    chk("reset dir", dir_out, 4'b1100);
    chk("reset full", q_full, 0);
    cyc(0, 0, 1, 0, 0);
    chk("idle tick chg", dir_changed, 0);
    chk("idle tick dir", dir_out, 4'b1100);
    cyc(2'b01, 4'b0001, 0, 0, 0);
    chk("p0 right accept", req_dropped, 0);
    cyc(0, 0, 1, 0, 0);
    chk("p0 right commit", dir_out, 4'b1101);
    chk("p0 right chg", dir_changed, 2'b01);
    cyc(0, 0, 0, 0, 0);
    chk("chg one cycle", dir_changed, 0);
    cyc(2'b01, 4'b0010, 0, 0, 0);
    chk("reversal drop", req_dropped, 2'b01);
    chk("reversal dir", dir_out, 4'b1101);
    cyc(0, 0, 0, 0, 1);
    chk("clear dir", dir_out, 4'b1100);
    cyc(2'b01, 4'b0001, 0, 0, 0);
    cyc(2'b01, 4'b0011, 0, 0, 0);
    chk("two turns full", q_full, 2'b01);
    chk("two turns kept", req_dropped, 0);
    cyc(2'b01, 4'b0010, 0, 0, 0);
    chk("full drop", req_dropped, 2'b01);
    cyc(0, 0, 1, 0, 0);
    chk("first commit", dir_out, 4'b1101);
    cyc(0, 0, 1, 0, 0);
    chk("second commit", dir_out, 4'b1111);
    cyc(2'b01, 4'b0010, 0, 0, 0);
    cyc(2'b01, 4'b0000, 0, 0, 0);
    cyc(2'b01, 4'b0001, 1, 0, 0);
    chk("push pop full", q_full, 2'b01);
    chk("push pop no drop", req_dropped, 0);
    chk("push pop dir", dir_out, 4'b1110);
    chk("push pop chg", dir_changed, 2'b01);
    cyc(2'b01, 4'b0010, 1, 1, 0);
    chk("freeze chg", dir_changed, 0);
    chk("freeze drop", req_dropped, 0);
    chk("freeze dir", dir_out, 4'b1110);
    chk("freeze full", q_full, 2'b01);
    cyc(0, 0, 1, 0, 0);
    chk("unfreeze c1", dir_out, 4'b1100);
    cyc(0, 0, 1, 0, 0);
    chk("unfreeze c2", dir_out, 4'b1101);
    cyc(2'b10, 4'b0100, 0, 0, 0);
    chk("p1 queued", req_dropped, 0);
    cyc(0, 0, 0, 0, 1);
    chk("clear mid", dir_out, 4'b1100);
    cyc(0, 0, 1, 0, 0);
    chk("clear flushed", dir_changed, 0);
    cyc(2'b01, 4'b0001, 0, 0, 0);
    cyc(2'b01, 4'b0011, 1, 0, 0);
    cyc(2'b01, 4'b0010, 0, 0, 0);
    #2 resetn = 0;
    #1;
    chk("async dir", dir_out, 4'b1100);
    chk("async full", q_full, 0);
    chk("async pulses", {dir_changed, req_dropped}, 0);
    model_reset();
    #3 resetn = 1;
    for (int n = 0; n < 3000; n++)
      cyc(2'($urandom), 4'($urandom), $urandom_range(0, 2) == 0, $urandom_range(0, 15) == 0, $urandom_range(0, 63) == 0);
    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/player_dir_queue.md
Name: player_dir_queue

Overview:
- N-player direction controller for the light-cycle game.
- Buffers each player's turn requests in a small per-player queue, rejecting reversals and redundant turns against the most recently accepted direction.
- Commits one queued turn per player on each game move tick, so two quick turns between ticks are both kept.
- Sits between the keyboard/key decoders and the per-player position/trail logic.

Parameters:
NUM_PLAYERS, 2, number of independent player channels (1..4)
QDEPTH, 2, turn-request queue depth per player (1..4)
INIT_DIRS, 4'b11_00, packed start directions, player i at bits [2i+1:2i]; default P0=UP, P1=DOWN

Ports:
CLOCK_50  input  1  system clock, all logic on rising edge
resetn  input  1  asynchronous active-low reset
clear  input  1  synchronous round restart: reload INIT_DIRS, flush queues
freeze  input  1  game paused/over: requests and ticks ignored
move_tick  input  1  one-cycle pulse, game step
dir_valid  input  NUM_PLAYERS  per-player request strobe
dir_req  input  2*NUM_PLAYERS  requested direction, player i at [2i+1:2i]
dir_out  output  2*NUM_PLAYERS  committed direction per player
dir_changed  output  NUM_PLAYERS  one-cycle pulse when dir_out[i] updates
req_dropped  output  NUM_PLAYERS  one-cycle pulse when a valid request is discarded
q_full  output  NUM_PLAYERS  queue i holds QDEPTH entries

Behaviour:
- Encoding: 00 UP, 01 RIGHT, 11 DOWN, 10 LEFT. Reverse of d is ~d (bitwise).
- resetn low (async): dir_out=INIT_DIRS, queues empty, dir_changed=0, req_dropped=0, q_full=0.
- Per player, "tail" = newest queued entry if the queue is non-empty, else dir_out[i].
- Request phase, evaluated when dir_valid[i]=1, freeze=0, clear=0:
  - dir_req==tail: discarded, req_dropped[i]=1.
  - dir_req==~tail (reversal): discarded, req_dropped[i]=1.
  - Queue full and no pop this cycle: discarded, req_dropped[i]=1.
  - Otherwise enqueue at tail.
- Commit phase, when move_tick=1, freeze=0, clear=0, queue i non-empty:
  - Pop head into dir_out[i] and pulse dir_changed[i] on the same edge.
  - Empty queue: dir_out[i] holds, no pulse.
- Latency: a request accepted in cycle t is visible on dir_out at the first move_tick edge after t. If tick and valid coincide on an empty queue, the request is enqueued only and commits on the following tick.
- Simultaneous push and pop:
  - Both occur; tail is computed from pre-edge state.
  - A full queue with pop accepts the push, and the count is unchanged.
- freeze=1:
  - No enqueue, no pop, no req_dropped pulses; dir_out and queues hold.
- clear=1:
  - Highest priority after reset.
  - dir_out<=INIT_DIRS, queues emptied.
  - dir_changed and req_dropped are 0 that cycle.
- Channels are fully independent; no cross-player interaction.
- Queue: circular buffer with head/tail pointers and a count. Pointers wrap modulo QDEPTH. Count width is $clog2(QDEPTH+1).
- q_full is registered from the post-edge count.
- dir_changed and req_dropped are registered pulses, high exactly one cycle per event.

Test Plan:
1. Reset with defaults -> dir_out=4'b11_00, q_full=0. Tick with no requests -> no dir_changed, dir_out unchanged.
2. P0 (dir_out=UP) request RIGHT, then tick -> dir_out[1:0]=01, dir_changed[0]=1 for one cycle. P0 request LEFT (10) -> req_dropped[0]=1, dir_out stays 01.
3. QDEPTH=2, P0=UP: requests RIGHT then DOWN between ticks -> both accepted (DOWN checked against tail RIGHT), q_full[0]=1. Third request LEFT -> dropped. Ticks -> 01, then 11.
4. Full queue with push and move_tick in the same cycle -> head pops, push accepted, q_full stays 1, req_dropped=0.
5. freeze=1 with requests and ticks -> no pulses, state held. Release freeze -> queued entries commit on subsequent ticks.
6. clear mid-queue (P1 queue holding RIGHT) -> dir_out=INIT_DIRS, queue empty. Assert resetn low between clock edges -> outputs reset immediately, without waiting for a clock edge.
